// File: rtl/load_fwd_buffer_if.sv
// Writeback-side load forwarding bus: push, pipeline control, two lookups and oldest-entry view.
// The master side is the pipeline; the slave side is load_fwd_buffer.
interface load_fwd_buffer_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic            stall;
    logic            flush;
    logic            push_we;
    logic [AW-1:0]   push_rd;
    logic [XLEN-1:0] push_data;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            hit1;
    logic [XLEN-1:0] data1;
    logic            hit2;
    logic [XLEN-1:0] data2;
    logic            old_we;
    logic [AW-1:0]   old_rd;
    logic [XLEN-1:0] old_data;
    logic [CW-1:0]   count;

    modport master (
        output stall, flush, push_we, push_rd, push_data, rs1, rs2,
        input  hit1, data1, hit2, data2, old_we, old_rd, old_data, count
    );

    modport slave (
        input  stall, flush, push_we, push_rd, push_data, rs1, rs2,
        output hit1, data1, hit2, data2, old_we, old_rd, old_data, count
    );
endinterface

// File: rtl/load_fwd_buffer.sv
// Age-ordered buffer of the last DEPTH writeback loads with two youngest-match forwarding lookups.
// Optional macro LFB_BYPASS_EN: lookups also see the live, unstalled push in the same cycle.
module load_fwd_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int AW    = 5
) (
    input  logic clk,
    input  logic reset,
    load_fwd_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t entries [DEPTH];

    // Writes to x0 are never forwarded, so they are stored as invalid.
    logic push_valid;
    assign push_valid = bus.push_we && (bus.push_rd != '0);

    // NOTE: the entries are ordinary flops feeding combinational lookups, so every one is
    // reset (not just the valid bits) and all state updates use non-blocking assignments.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
        end else if (!bus.stall) begin
            for (int i = DEPTH - 1; i > 0; i--) entries[i] <= entries[i-1];
            entries[0] <= '{valid: push_valid, rd: bus.push_rd, data: bus.push_data};
        end
    end

    logic            hit1_c;
    logic            hit2_c;
    logic [XLEN-1:0] data1_c;
    logic [XLEN-1:0] data2_c;
    logic [CW-1:0]   count_c;

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        hit1_c  = 1'b0;
        hit2_c  = 1'b0;
        data1_c = '0;
        data2_c = '0;
        count_c = '0;
        // Oldest to youngest, so the lowest matching index is written last and wins.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            count_c = count_c + CW'(entries[i].valid);
            if (entries[i].valid && entries[i].rd == bus.rs1 && bus.rs1 != '0) begin
                hit1_c  = 1'b1;
                data1_c = entries[i].data;
            end
            if (entries[i].valid && entries[i].rd == bus.rs2 && bus.rs2 != '0) begin
                hit2_c  = 1'b1;
                data2_c = entries[i].data;
            end
        end
`ifdef LFB_BYPASS_EN
        // A live push that will actually be captured beats every stored entry.
        if (push_valid && !bus.stall && !bus.flush) begin
            if (bus.push_rd == bus.rs1) begin
                hit1_c  = 1'b1;
                data1_c = bus.push_data;
            end
            if (bus.push_rd == bus.rs2) begin
                hit2_c  = 1'b1;
                data2_c = bus.push_data;
            end
        end
`endif
    end

    assign bus.hit1     = hit1_c;
    assign bus.data1    = data1_c;
    assign bus.hit2     = hit2_c;
    assign bus.data2    = data2_c;
    assign bus.count    = count_c;
    assign bus.old_we   = entries[DEPTH-1].valid;
    assign bus.old_rd   = entries[DEPTH-1].rd;
    assign bus.old_data = entries[DEPTH-1].data;
endmodule
